// File: rtl/rid_error_tracker_pkg.sv
// Shared types and width helpers for the DDR read-ID error tracker.
// Provides rid_w(), err_code_t and BLANK_W for the tracker slice.
package ddr_err_pkg;

  localparam int BLANK_W    = 4;
  localparam int CODE_W_DEF = 2;

  typedef logic [CODE_W_DEF-1:0] err_code_t;

  // ID width; at least one bit even for tiny ID spaces
  function automatic int rid_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rid_error_tracker_if.sv
// Error-report and clear bus into the read-ID error tracker.
// master: checker/arbiter side drives; slave: tracker consumes.
interface rid_error_tracker_if #(
  parameter int NUM_IDS = 4,
  parameter int CODE_W  = 2
);
  import ddr_err_pkg::*;

  localparam int RID_W = rid_w(NUM_IDS);

  logic              clear;
  logic [RID_W-1:0]  clear_rid;
  logic              err;
  logic [RID_W-1:0]  err_rid;
  logic [CODE_W-1:0] err_code;

  modport master (
    output clear, clear_rid,
    output err, err_rid, err_code
  );

  modport slave (
    input clear, clear_rid,
    input err, err_rid, err_code
  );

endinterface

// File: rtl/rid_error_tracker_blank_timer.sv
// Per-ID post-clear blanking timer (module rid_blank_timer).
// Ports: clk, n_rst (sync, active-low), load, blanked.
module rid_blank_timer
  import ddr_err_pkg::*;
#(
  parameter int BLANK_CYCLES = 1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic load,
  output logic blanked
);

  logic [BLANK_W-1:0] tmr_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      tmr_q <= '0;
    end else if (load) begin
      tmr_q <= BLANK_W'(BLANK_CYCLES);
    end else if (tmr_q != '0) begin
      tmr_q <= tmr_q - 1'b1;
    end
  end

  assign blanked = (tmr_q != '0);

endmodule

// File: rtl/rid_error_tracker.sv
// Per-read-ID sticky error/code/multi-error tracker with blanking.
// Ports: clk, n_rst, bus (slave), error, multi_err, code_out, irq,
// err_cnt. ERR_TRK_CNT_EN adds per-ID saturating error counters.
module rid_error_tracker
  import ddr_err_pkg::*;
#(
  parameter int NUM_IDS      = 4,
  parameter int CODE_W       = 2,
  parameter int BLANK_CYCLES = 1,
  parameter int CNT_W        = 4
) (
  input  logic                      clk,
  input  logic                      n_rst,
  rid_error_tracker_if.slave        bus,
  output logic [NUM_IDS-1:0]        error,
  output logic [NUM_IDS-1:0]        multi_err,
  output logic [NUM_IDS*CODE_W-1:0] code_out,
  output logic                      irq,
  output logic [NUM_IDS*CNT_W-1:0]  err_cnt
);

  localparam int RID_W = rid_w(NUM_IDS);

  logic [NUM_IDS-1:0] blanked;

  for (genvar i = 0; i < NUM_IDS; i++) begin : g_id
    localparam logic [RID_W-1:0] ID = RID_W'(i);

    logic              clr_hit;
    logic              acc;
    logic              err_q;
    logic              mul_q;
    logic [CODE_W-1:0] code_q;

    // rids >= NUM_IDS never match any slot, so they are ignored
    assign clr_hit = bus.clear && (bus.clear_rid == ID);
    assign acc     = bus.err && (bus.err_rid == ID)
                   && !blanked[i] && !clr_hit;

    rid_blank_timer #(
      .BLANK_CYCLES (BLANK_CYCLES)
    ) u_tmr (
      .clk     (clk),
      .n_rst   (n_rst),
      .load    (clr_hit),
      .blanked (blanked[i])
    );

    always_ff @(posedge clk) begin
      if (!n_rst) begin
        err_q  <= 1'b0;
        mul_q  <= 1'b0;
        code_q <= '0;
      end else if (clr_hit) begin
        err_q  <= 1'b0;
        mul_q  <= 1'b0;
        code_q <= '0;
      end else if (acc) begin
        if (!err_q) begin
          err_q  <= 1'b1;
          code_q <= bus.err_code;
        end else begin
          mul_q  <= 1'b1;
        end
      end
    end

    assign error[i]                    = err_q;
    assign multi_err[i]                = mul_q;
    assign code_out[i*CODE_W +: CODE_W] = code_q;

`ifdef ERR_TRK_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
      if (!n_rst) begin
        cnt_q <= '0;
      end else if (clr_hit) begin
        cnt_q <= '0;
      end else if (acc && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign err_cnt[i*CNT_W +: CNT_W] = cnt_q;
`else
    assign err_cnt[i*CNT_W +: CNT_W] = '0;
`endif
  end

  assign irq = |error;

endmodule

// File: tb/tb_rid_error_tracker.sv
// Bench for rid_error_tracker: table vectors, corner sequences and
// random traffic against a cycle-count based reference model.
module tb_rid_error_tracker;
  import ddr_err_pkg::*;

  localparam int N    = 4;
  localparam int CW   = 2;
  localparam int CNTW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic n_rst;

  rid_error_tracker_if #(.NUM_IDS(N), .CODE_W(CW)) bus1 ();
  rid_error_tracker_if #(.NUM_IDS(N), .CODE_W(CW)) bus3 ();

  logic [N-1:0]      o1_err, o1_mul, o3_err, o3_mul;
  logic [N*CW-1:0]   o1_code, o3_code;
  logic              o1_irq, o3_irq;
  logic [N*CNTW-1:0] o1_cnt, o3_cnt;

  rid_error_tracker #(
    .NUM_IDS(N), .CODE_W(CW), .BLANK_CYCLES(1), .CNT_W(CNTW)
  ) u_d1 (
    .clk(clk), .n_rst(n_rst), .bus(bus1),
    .error(o1_err), .multi_err(o1_mul), .code_out(o1_code),
    .irq(o1_irq), .err_cnt(o1_cnt)
  );

  rid_error_tracker #(
    .NUM_IDS(N), .CODE_W(CW), .BLANK_CYCLES(3), .CNT_W(CNTW)
  ) u_d3 (
    .clk(clk), .n_rst(n_rst), .bus(bus3),
    .error(o3_err), .multi_err(o3_mul), .code_out(o3_code),
    .irq(o3_irq), .err_cnt(o3_cnt)
  );

  int checks = 0;
  int errors = 0;

  // reference state: dut 0 has blank 1, dut 1 has blank 3
  bit        m_err [2][N];
  bit        m_mul [2][N];
  err_code_t m_code[2][N];
  int        m_cnt [2][N];
  int        m_lc  [2][N];
  int        blank_of[2] = '{1, 3};
  int        cyc_n = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc_n, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N; i++) begin
        m_err[d][i]  = 0;
        m_mul[d][i]  = 0;
        m_code[d][i] = '0;
        m_cnt[d][i]  = 0;
        m_lc[d][i]   = -1000;
      end
  endtask

  // an ID is blanked for blank_of cycles after the cycle of its clear
  task automatic model_edge(input bit rst, input bit clr,
                            input bit [1:0] crid, input bit e,
                            input bit [1:0] erid, input bit [1:0] code);
    cyc_n++;
    if (rst) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N; i++) begin
        bit c, a;
        c = clr && (int'(crid) == i);
        a = e && (int'(erid) == i) && !c
          && !((cyc_n - m_lc[d][i]) <= blank_of[d]);
        if (c) begin
          m_err[d][i]  = 0;
          m_mul[d][i]  = 0;
          m_code[d][i] = '0;
          m_cnt[d][i]  = 0;
          m_lc[d][i]   = cyc_n;
        end else if (a) begin
          if (m_err[d][i]) m_mul[d][i] = 1;
          else begin
            m_err[d][i]  = 1;
            m_code[d][i] = code;
          end
          if (m_cnt[d][i] < (1 << CNTW) - 1) m_cnt[d][i]++;
        end
      end
  endtask

  task automatic model_check();
    for (int d = 0; d < 2; d++) begin
      logic [N-1:0]      xe, xm;
      logic [N*CW-1:0]   xc;
      logic [N*CNTW-1:0] xn;
      for (int i = 0; i < N; i++) begin
        xe[i] = m_err[d][i];
        xm[i] = m_mul[d][i];
        xc[i*CW +: CW] = m_code[d][i];
`ifdef ERR_TRK_CNT_EN
        xn[i*CNTW +: CNTW] = CNTW'(m_cnt[d][i]);
`else
        xn[i*CNTW +: CNTW] = '0;
`endif
      end
      if (d == 0) begin
        chk("m1_error", 32'(o1_err), 32'(xe));
        chk("m1_multi", 32'(o1_mul), 32'(xm));
        chk("m1_code", 32'(o1_code), 32'(xc));
        chk("m1_irq", 32'(o1_irq), 32'(|xe));
        chk("m1_cnt", 32'(o1_cnt), 32'(xn));
      end else begin
        chk("m3_error", 32'(o3_err), 32'(xe));
        chk("m3_multi", 32'(o3_mul), 32'(xm));
        chk("m3_code", 32'(o3_code), 32'(xc));
        chk("m3_irq", 32'(o3_irq), 32'(|xe));
        chk("m3_cnt", 32'(o3_cnt), 32'(xn));
      end
    end
  endtask

  task automatic cyc(input bit rst, input bit clr, input bit [1:0] crid,
                     input bit e, input bit [1:0] erid,
                     input bit [1:0] code);
    n_rst          = !rst;
    bus1.clear     = clr;  bus3.clear     = clr;
    bus1.clear_rid = crid; bus3.clear_rid = crid;
    bus1.err       = e;    bus3.err       = e;
    bus1.err_rid   = erid; bus3.err_rid   = erid;
    bus1.err_code  = code; bus3.err_code  = code;
    @(posedge clk);
    model_edge(rst, clr, crid, e, erid, code);
    #1;
    model_check();
  endtask

  typedef struct {
    bit       rst;
    bit       clr;
    bit [1:0] crid;
    bit       e;
    bit [1:0] erid;
    bit [1:0] code;
    bit [3:0] x_err;
    bit [3:0] x_mul;
    bit [7:0] x_code;
  } vec_t;

  vec_t tbl[14];

  initial begin
    model_reset();
    n_rst = 1'b0;
    bus1.clear = 0; bus1.clear_rid = 0; bus1.err = 0;
    bus1.err_rid = 0; bus1.err_code = 0;
    bus3.clear = 0; bus3.clear_rid = 0; bus3.err = 0;
    bus3.err_rid = 0; bus3.err_code = 0;

    // expectations are for the BLANK_CYCLES=1 instance
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 8'h00};
    tbl[1]  = '{1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 8'h00};
    tbl[2]  = '{0, 0, 0, 1, 2, 2, 4'b0100, 4'b0000, 8'h20};
    tbl[3]  = '{0, 0, 0, 1, 2, 1, 4'b0100, 4'b0100, 8'h20};
    tbl[4]  = '{0, 1, 2, 0, 0, 0, 4'b0000, 4'b0000, 8'h00};
    tbl[5]  = '{0, 0, 0, 1, 2, 3, 4'b0000, 4'b0000, 8'h00};
    tbl[6]  = '{0, 0, 0, 1, 2, 3, 4'b0100, 4'b0000, 8'h30};
    tbl[7]  = '{0, 1, 1, 1, 1, 2, 4'b0100, 4'b0000, 8'h30};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 4'b0100, 4'b0000, 8'h30};
    tbl[9]  = '{0, 1, 1, 1, 3, 1, 4'b1100, 4'b0000, 8'h70};
    tbl[10] = '{0, 0, 0, 1, 1, 0, 4'b1100, 4'b0000, 8'h70};
    tbl[11] = '{0, 0, 0, 1, 1, 0, 4'b1110, 4'b0000, 8'h70};
    tbl[12] = '{1, 0, 0, 1, 2, 1, 4'b0000, 4'b0000, 8'h00};
    tbl[13] = '{0, 0, 0, 1, 3, 2, 4'b1000, 4'b0000, 8'h80};

    for (int k = 0; k < 14; k++) begin
      cyc(tbl[k].rst, tbl[k].clr, tbl[k].crid,
          tbl[k].e, tbl[k].erid, tbl[k].code);
      chk($sformatf("t%0d_error", k), 32'(o1_err), 32'(tbl[k].x_err));
      chk($sformatf("t%0d_multi", k), 32'(o1_mul), 32'(tbl[k].x_mul));
      chk($sformatf("t%0d_code", k), 32'(o1_code), 32'(tbl[k].x_code));
      chk($sformatf("t%0d_irq", k), 32'(o1_irq), 32'(|tbl[k].x_err));
    end

    // three-cycle blanking on the second instance
    cyc(0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      cyc(0, 0, 0, 1, 0, 1);
      chk($sformatf("b3_blank%0d", k), 32'(o3_err[0]), 32'd0);
    end
    cyc(0, 0, 0, 1, 0, 2);
    chk("b3_accept", 32'(o3_err[0]), 32'd1);
    chk("b3_code", 32'(o3_code[1:0]), 32'd2);

    // counter saturation and clear
    for (int k = 0; k < 20; k++) cyc(0, 0, 0, 1, 0, 3);
`ifdef ERR_TRK_CNT_EN
    chk("cnt_sat", 32'(o3_cnt[3:0]), 32'd15);
`else
    chk("cnt_sat", 32'(o3_cnt[3:0]), 32'd0);
`endif
    cyc(0, 1, 0, 0, 0, 0);
    chk("cnt_clr", 32'(o3_cnt[3:0]), 32'd0);
    chk("cnt_clr_err", 32'(o3_err[0]), 32'd0);

    // mid-traffic reset then immediate accept
    cyc(0, 0, 0, 1, 1, 1);
    cyc(0, 1, 2, 1, 3, 2);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_mid_err", 32'(o3_err), 32'd0);
    cyc(0, 0, 0, 1, 2, 3);
    chk("rst_next_acc", 32'(o3_err), 32'b0100);

    for (int k = 0; k < 3000; k++) begin
      bit r;
      r = ($urandom_range(99) == 0);
      cyc(r, $urandom_range(4) == 0, 2'($urandom),
          $urandom_range(1) == 1, 2'($urandom), 2'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
